// File: rtl/see_weight_fetcher.sv
// see_weight_fetcher: reader side of the synchronous-read weight ROM.
// Issues one contiguous burst of ROM addresses per job, captures the returned
// signed weights in a 2-entry output FIFO and streams them over valid/ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-cycle job request, accepted only while idle
//   base_addr, length     burst description, sampled with an accepted start
//   rom_addr / rom_data   weight ROM interface (data valid 1 cycle after addr)
//   w_valid/w_ready       output handshake; w_data is the weight, w_last
//                         marks the final word of the burst
//   busy                  high while fetching/draining a burst
//   done                  1-cycle pulse after the final handshake
//   checksum              (FETCH_CHECKSUM_EN only) 16-bit sign-extended sum
//                         of the weights accepted in the current burst
//
// Optional feature macro: FETCH_CHECKSUM_EN.
module see_weight_fetcher #(
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LEN_W    = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [LEN_W-1:0]           length,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic signed [WEIGHT_W-1:0] rom_data,
  output logic                       w_valid,
  input  logic                       w_ready,
  output logic signed [WEIGHT_W-1:0] w_data,
  output logic                       w_last,
  output logic                       busy,
  output logic                       done
`ifdef FETCH_CHECKSUM_EN
  ,
  output logic [15:0]                checksum
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                     state_q;
  logic [ADDR_W-1:0]          addr_q;       // next address to issue
  logic [ADDR_W-1:0]          last_addr_q;  // most recently issued address
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           issue_cnt_q;
  logic [LEN_W-1:0]           out_cnt_q;
  logic                       rd_q;         // a read is in flight on rom_data
  logic [1:0]                 occ_q;
  logic signed [WEIGHT_W-1:0] head_q;
  logic signed [WEIGHT_W-1:0] tail_q;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] credit;

  assign pop  = w_valid & w_ready;
  assign push = rd_q;

  // Slots committed after this cycle's pop: buffered words plus the read in
  // flight. Crediting the same-cycle pop is what allows 1 word/cycle with only
  // two entries; a word issued now lands in the FIFO two edges later, by which
  // time at most one other word can be occupying it.
  assign credit = {1'b0, occ_q} + {2'b00, rd_q} - {2'b00, pop};
  assign issue  = (state_q == StFetch) && (issue_cnt_q != len_q) && (credit < 3'd2);

  // Address is presented in the issue cycle; otherwise the last one is held.
  assign rom_addr = issue ? addr_q : last_addr_q;

  assign w_valid = (occ_q != 2'd0);
  assign w_data  = head_q;
  assign w_last  = w_valid && (out_cnt_q == len_q - LEN_W'(1));
  assign busy    = (state_q == StFetch) || (state_q == StDrain);
  assign done    = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      last_addr_q <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      rd_q        <= 1'b0;
    end else begin
      rd_q <= issue;
      if (issue) begin
        addr_q      <= addr_q + ADDR_W'(1);
        last_addr_q <= addr_q;
        issue_cnt_q <= issue_cnt_q + LEN_W'(1);
      end
      if (pop) begin
        out_cnt_q <= out_cnt_q + LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q      <= base_addr;
            len_q       <= length;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            state_q     <= (length == '0) ? StDone : StFetch;
          end
        end
        StFetch: begin
          if (issue && (issue_cnt_q + LEN_W'(1) == len_q)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && w_last) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // 2-entry FIFO; head_q drives w_data directly so a write into the second
  // entry never disturbs a word that is waiting for its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= rom_data;
          end else begin
            tail_q <= rom_data;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
          end
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy 2 with a push is excluded by the issue credit.
          if (occ_q == 2'd1) begin
            head_q <= rom_data;
          end else begin
            head_q <= tail_q;
            tail_q <= rom_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_CHECKSUM_EN
  logic [15:0] w_ext;
  assign w_ext = 16'(w_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if ((state_q == StIdle) && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + w_ext;
    end
  end
`endif

endmodule

// File: tb/tb_see_weight_fetcher.sv
// Self-checking bench for see_weight_fetcher: a table of bursts with known
// timing, directed reset/checksum sequences, then randomized bursts checked
// against a reference built from the ROM contents and the burst description.
module tb_see_weight_fetcher;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [9:0]        base_addr = '0;
  logic [10:0]       length = '0;
  logic [9:0]        rom_addr;
  logic signed [7:0] rom_data = '0;
  logic              w_valid;
  logic              w_ready = 1'b0;
  logic signed [7:0] w_data;
  logic              w_last;
  logic              busy;
  logic              done;
`ifdef FETCH_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  logic [7:0] mem [0:1023];
  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    logic [15:0] pat;      // w_ready pattern indexed by cycle mod 16
    int          exp_cyc;  // expected done cycle (0: timing not checked)
    int          ign_cyc;  // cycle of an extra start that must be ignored (0: none)
  } vec_t;

  see_weight_fetcher #(
    .WEIGHT_W(8),
    .ADDR_W  (10),
    .LEN_W   (11)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_last   (w_last),
    .busy     (busy),
    .done     (done)
`ifdef FETCH_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM, 1-cycle latency.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
    chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_w_data", {24'd0, w_data}, 32'd0);
    chk("rst_w_last", {31'd0, w_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
  endtask

  // Runs one burst; cycle 0 is the start cycle. Expected words are
  // mem[(base+k) mod 1024] in order, w_last on k==len-1, done the cycle after
  // the final handshake (cycle 1 for an empty burst).
  task automatic run_burst(input logic [9:0] base, input logic [10:0] len,
                           input logic [15:0] pat, input int exp_cyc, input int ign_cyc);
    int          k = 0;
    int          cyc = 0;
    int          a;
    bit          fin = 0;
    bit          last_hs = 0;
    bit          exp_done;
    bit          prev_stall = 0;
    logic [7:0]  prev_d = '0;
    logic        prev_l = 1'b0;
    logic [15:0] sum = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = len; w_ready = pat[0];
    while (!fin && cyc < 20 * int'(len) + 40) begin
      @(posedge clk); #1;
      cyc++;
      w_ready = pat[cyc % 16];
      start = (cyc == ign_cyc);
      if (start) begin
        base_addr = ~base; length = 11'd3;
      end
      @(negedge clk);
      exp_done = (len == 0) ? (cyc == 1) : last_hs;
      last_hs = 0;
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("busy", {31'd0, busy}, {31'd0, !exp_done});
      if (exp_cyc != 0 && cyc >= 1 && cyc <= int'(len))
        chk("rom_addr", {22'd0, rom_addr}, (int'(base) + cyc - 1) % 1024);
      if (exp_cyc != 0)
        chk("w_valid_timing", {31'd0, w_valid}, {31'd0, (cyc >= 3 && cyc <= int'(len) + 2)});
      if (prev_stall) begin
        chk("stall_valid", {31'd0, w_valid}, 32'd1);
        chk("stall_data", {24'd0, w_data}, {24'd0, prev_d});
        chk("stall_last", {31'd0, w_last}, {31'd0, prev_l});
      end
      if (w_valid && w_ready) begin
        if (k >= int'(len)) begin
          chk("extra_word", k, len);
        end else begin
          a = (int'(base) + k) % 1024;
          chk("w_data", {24'd0, w_data}, {24'd0, mem[a]});
          chk("w_last", {31'd0, w_last}, {31'd0, (k == int'(len) - 1)});
          sum = sum + {{8{mem[a][7]}}, mem[a]};
          last_hs = (k == int'(len) - 1);
        end
        k++;
      end
      prev_stall = w_valid && !w_ready;
      prev_d = w_data;
      prev_l = w_last;
      if (exp_done) begin
        fin = 1;
        chk("word_count", k, len);
        if (exp_cyc != 0) chk("done_cycle", cyc, exp_cyc);
`ifdef FETCH_CHECKSUM_EN
        chk("checksum", {16'd0, checksum}, {16'd0, sum});
`endif
      end
    end
    start = 1'b0;
    if (!fin) begin
      errs++;
      $display("FAIL burst_timeout: actual no done required done base %0d len %0d", base, len);
    end
  endtask

  initial begin
    vec_t tbl [8];
    int   hs;
    tbl[0] = '{10'd5,    11'd4, 16'hFFFF, 7, 0};
    tbl[1] = '{10'd1022, 11'd4, 16'hFFFF, 7, 0};
    tbl[2] = '{10'd0,    11'd1, 16'hFFFF, 4, 0};
    tbl[3] = '{10'd10,   11'd6, 16'h4A59, 0, 0};
    tbl[4] = '{10'd0,    11'd0, 16'hFFFF, 1, 0};
    tbl[5] = '{10'd100,  11'd6, 16'hFFFF, 9, 2};
    tbl[6] = '{10'd50,   11'd3, 16'h5555, 0, 0};
    tbl[7] = '{10'd1023, 11'd2, 16'hFFFF, 5, 0};

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

    #12;
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_burst(tbl[i].base, tbl[i].len, tbl[i].pat, tbl[i].exp_cyc, tbl[i].ign_cyc);

    // Zero-length start issued during the DONE cycle of an empty job.
    run_burst(10'd7, 11'd0, 16'hFFFF, 1, 1);

    // Reset in the middle of a burst.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd200; length = 11'd8; w_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 30 && hs < 3; c++) begin
      @(negedge clk);
      if (w_valid && w_ready) begin
        chk("rst_burst_data", {24'd0, w_data}, {24'd0, mem[200 + hs]});
        hs++;
      end
      if (hs < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("rst_burst_hs", hs, 3);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_valid", {31'd0, w_valid}, 32'd0);
    end
    run_burst(10'd300, 11'd5, 16'hFFFF, 8, 0);

`ifdef FETCH_CHECKSUM_EN
    mem[300] = 8'hFD; mem[301] = 8'h05; mem[302] = 8'h80; mem[303] = 8'h7F;
    run_burst(10'd300, 11'd4, 16'hFFFF, 7, 0);
    @(negedge clk);
    chk("checksum_held", {16'd0, checksum}, 32'h0001);
`endif

    // Randomized bursts over random ROM contents.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] pat;
      pat = 16'($urandom) | 16'h0001;
      run_burst(10'($urandom), 11'($urandom_range(0, 40)), pat, 0, $urandom_range(0, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
